// File: rtl/ascon_io_pkg.sv
// Shared definitions for the Ascon byte-serial host interface.
//   state_t  : top-level FSM states (load lanes, run core, unload result, finish)
//   NSHARE   : number of Boolean shares carried per lane
//   LANE_W   : bits per share within one lane byte
//   max_int  : helper used to size the derived widths
package ascon_io_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    localparam int NSHARE = 3;
    localparam int LANE_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascon_share_field.sv
// Three W-bit share registers filled one byte per accepted lane, MSB first.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   i_we      : lane byte is accepted this cycle
//   i_idx     : byte index j of the accepted lane byte
//   i_lane    : 24-bit lane, share s in bits [8s+7:8s]
//   o_sh      : share s of the field in bits [s*W +: W]
// Byte j lands in bits [W-1-8j -: 8] of each share; indices beyond W/8 match
// no register and are therefore ignored by this field.
module ascon_share_field
    import ascon_io_pkg::*;
#(
    parameter int W  = 128,
    parameter int IW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [IW-1:0]              i_idx,
    input  logic [NSHARE*LANE_W-1:0]   i_lane,
    output logic [NSHARE*W-1:0]        o_sh
);

    localparam int NB = W / LANE_W;

    genvar gs, gi;
    generate
        for (gs = 0; gs < NSHARE; gs++) begin : g_share
            for (gi = 0; gi < NB; gi++) begin : g_byte
                logic [LANE_W-1:0] r_byte;

                always_ff @(posedge clk) begin
                    if (!rst) begin
                        r_byte <= '0;
                    end else if (i_we && (i_idx == IW'(gi))) begin
                        r_byte <= i_lane[gs*LANE_W +: LANE_W];
                    end
                end

                assign o_sh[gs*W + W-1-LANE_W*gi -: LANE_W] = r_byte;
            end
        end
    endgenerate

endmodule

// File: rtl/ascon_serial_io.sv
// Byte-serial host interface for the Ascon decryption core.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   keyxSI/noncexSI/associated_dataxSI/cipher_textxSI : 24-bit share lanes
//   in_validxSI                    : lane byte valid
//   decryption_startxSI            : host start command (honoured once loaded)
//   loadedxSO                      : all NIN bytes captured
//   key_shxSO/nonce_shxSO/ad_shxSO/ct_shxSO : parallel share registers
//   core_startxSO                  : one-cycle start to the core
//   core_readyxSI, core_ptxSI, core_tagxSI : core completion and result
//   plain_textxSO, tagxSO, out_validxSO, out_readyxSI : byte output stream
//   donexSO                        : pulse after the last output byte
module ascon_serial_io
    import ascon_io_pkg::*;
#(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSHARE*LANE_W-1:0]  keyxSI,
    input  logic [NSHARE*LANE_W-1:0]  noncexSI,
    input  logic [NSHARE*LANE_W-1:0]  associated_dataxSI,
    input  logic [NSHARE*LANE_W-1:0]  cipher_textxSI,
    input  logic                      in_validxSI,
    input  logic                      decryption_startxSI,
    output logic                      loadedxSO,
    output logic [NSHARE*K-1:0]       key_shxSO,
    output logic [NSHARE*128-1:0]     nonce_shxSO,
    output logic [NSHARE*L-1:0]       ad_shxSO,
    output logic [NSHARE*Y-1:0]       ct_shxSO,
    output logic                      core_startxSO,
    input  logic                      core_readyxSI,
    input  logic [Y-1:0]              core_ptxSI,
    input  logic [127:0]              core_tagxSI,
    output logic [LANE_W-1:0]         plain_textxSO,
    output logic [LANE_W-1:0]         tagxSO,
    output logic                      out_validxSO,
    input  logic                      out_readyxSI,
    output logic                      donexSO
);

    localparam int MAX  = max_int(max_int(K, L), max_int(Y, 128));
    localparam int NIN  = MAX / LANE_W;
    localparam int NOUT = max_int(Y, 128) / LANE_W;
    localparam int IW   = $clog2(NIN);
    localparam int OW   = $clog2(NOUT);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_loaded;
    logic            r_run_first;
    logic [IW-1:0]   r_in_idx;
    logic [OW-1:0]   r_out_idx;
    logic [Y-1:0]    r_pt;
    logic [127:0]    r_tag;

    logic            w_in_accept;
    logic            w_out_hs;
    logic            w_out_last;
    logic [LANE_W-1:0] w_pt_byte  [NOUT];
    logic [LANE_W-1:0] w_tag_byte [NOUT];

    assign w_in_accept = (r_state == ST_LOAD) && !r_loaded && in_validxSI;
    assign w_out_hs    = (r_state == ST_UNLOAD) && out_readyxSI;
    assign w_out_last  = (r_out_idx == OW'(NOUT-1));
    assign loadedxSO   = r_loaded;

    ascon_share_field #(.W(K),   .IW(IW)) u_key   (.clk(clk), .rst(rst), .i_we(w_in_accept), .i_idx(r_in_idx), .i_lane(keyxSI),             .o_sh(key_shxSO));
    ascon_share_field #(.W(128), .IW(IW)) u_nonce (.clk(clk), .rst(rst), .i_we(w_in_accept), .i_idx(r_in_idx), .i_lane(noncexSI),           .o_sh(nonce_shxSO));
    ascon_share_field #(.W(L),   .IW(IW)) u_ad    (.clk(clk), .rst(rst), .i_we(w_in_accept), .i_idx(r_in_idx), .i_lane(associated_dataxSI), .o_sh(ad_shxSO));
    ascon_share_field #(.W(Y),   .IW(IW)) u_ct    (.clk(clk), .rst(rst), .i_we(w_in_accept), .i_idx(r_in_idx), .i_lane(cipher_textxSI),     .o_sh(ct_shxSO));

    // Output byte tables: LSB byte first, zero-padded past the field width.
    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_out_byte
            if (gi < Y/LANE_W) begin : g_pt
                assign w_pt_byte[gi] = r_pt[LANE_W*gi +: LANE_W];
            end else begin : g_pt_pad
                assign w_pt_byte[gi] = '0;
            end
            if (gi < 128/LANE_W) begin : g_tag
                assign w_tag_byte[gi] = r_tag[LANE_W*gi +: LANE_W];
            end else begin : g_tag_pad
                assign w_tag_byte[gi] = '0;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_LOAD;
        else      r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:   if (r_loaded && decryption_startxSI) w_state_next = ST_RUN;
            ST_RUN:    if (core_readyxSI)                   w_state_next = ST_UNLOAD;
            ST_UNLOAD: if (w_out_hs && w_out_last)          w_state_next = ST_FIN;
            ST_FIN:                                         w_state_next = ST_LOAD;
            default:                                        w_state_next = ST_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        core_startxSO = 1'b0;
        out_validxSO  = 1'b0;
        donexSO       = 1'b0;
        plain_textxSO = '0;
        tagxSO        = '0;
        case (r_state)
            ST_RUN:    core_startxSO = r_run_first;
            ST_UNLOAD: begin
                out_validxSO  = 1'b1;
                plain_textxSO = w_pt_byte[r_out_idx];
                tagxSO        = w_tag_byte[r_out_idx];
            end
            ST_FIN:    donexSO = 1'b1;
            default:   ;
        endcase
    end

    // Counters, load flag and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_loaded    <= 1'b0;
            r_run_first <= 1'b0;
            r_in_idx    <= '0;
            r_out_idx   <= '0;
            r_pt        <= '0;
            r_tag       <= '0;
        end else begin
            // Marks only the first RUN cycle, however long start is held.
            r_run_first <= (r_state == ST_LOAD) && (w_state_next == ST_RUN);
            if (w_in_accept) begin
                r_in_idx <= r_in_idx + IW'(1);
                if (r_in_idx == IW'(NIN-1)) r_loaded <= 1'b1;
            end
            if ((r_state == ST_RUN) && core_readyxSI) begin
                r_pt  <= core_ptxSI;
                r_tag <= core_tagxSI;
            end
            if (w_out_hs) r_out_idx <= r_out_idx + OW'(1);
            if (r_state == ST_FIN) begin
                r_loaded  <= 1'b0;
                r_in_idx  <= '0;
                r_out_idx <= '0;
                r_pt      <= '0;
                r_tag     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ascon_serial_io.sv
module tb_ascon_serial_io;

    localparam int K = 128;
    localparam int L = 40;
    localparam int Y = 80;

    localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
    localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [79:0]  CT    = 80'h87a59a2ea49b233259e3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [23:0] key_l = '0, nonce_l = '0, ad_l = '0, ct_l = '0;
    logic in_valid = 1'b0, dstart = 1'b0, core_ready = 1'b0, out_ready = 1'b0;
    logic [Y-1:0]  core_pt  = '0;
    logic [127:0]  core_tag = '0;

    logic          loaded, core_start, out_valid, done;
    logic [3*K-1:0]   key_sh;
    logic [383:0]     nonce_sh;
    logic [3*L-1:0]   ad_sh;
    logic [3*Y-1:0]   ct_sh;
    logic [7:0]    pt_byte, tag_byte;

    int errors = 0;
    int checks = 0;

    logic [127:0] k_sh [3];
    logic [127:0] n_sh [3];
    logic [39:0]  a_sh [3];
    logic [79:0]  c_sh [3];

    ascon_serial_io #(.K(K), .L(L), .Y(Y)) dut (
        .clk(clk), .rst(rst),
        .keyxSI(key_l), .noncexSI(nonce_l), .associated_dataxSI(ad_l), .cipher_textxSI(ct_l),
        .in_validxSI(in_valid), .decryption_startxSI(dstart), .loadedxSO(loaded),
        .key_shxSO(key_sh), .nonce_shxSO(nonce_sh), .ad_shxSO(ad_sh), .ct_shxSO(ct_sh),
        .core_startxSO(core_start), .core_readyxSI(core_ready), .core_ptxSI(core_pt),
        .core_tagxSI(core_tag), .plain_textxSO(pt_byte), .tagxSO(tag_byte),
        .out_validxSO(out_valid), .out_readyxSI(out_ready), .donexSO(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_unmasked();
        k_sh[0] = KEY;   k_sh[1] = '0; k_sh[2] = '0;
        n_sh[0] = NONCE; n_sh[1] = '0; n_sh[2] = '0;
        a_sh[0] = AD;    a_sh[1] = '0; a_sh[2] = '0;
        c_sh[0] = CT;    c_sh[1] = '0; c_sh[2] = '0;
    endtask

    task automatic set_masked();
        for (int s = 1; s < 3; s++) begin
            k_sh[s] = {$urandom, $urandom, $urandom, $urandom};
            n_sh[s] = {$urandom, $urandom, $urandom, $urandom};
            a_sh[s] = 40'({$urandom, $urandom});
            c_sh[s] = 80'({$urandom, $urandom, $urandom});
        end
        k_sh[0] = KEY   ^ k_sh[1] ^ k_sh[2];
        n_sh[0] = NONCE ^ n_sh[1] ^ n_sh[2];
        a_sh[0] = AD    ^ a_sh[1] ^ a_sh[2];
        c_sh[0] = CT    ^ c_sh[1] ^ c_sh[2];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 0; dstart = 0; core_ready = 0; out_ready = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Presents 16 lane bytes (optionally with an idle, start-asserting cycle
    // between bytes); returns at the negedge after the last byte was taken.
    task automatic drive_load(input bit gapped, output int early_loaded, output int start_seen);
        early_loaded = 0;
        start_seen   = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (loaded)     early_loaded++;
            if (core_start) start_seen++;
            in_valid = 1'b1;
            dstart   = 1'b0;
            for (int s = 0; s < 3; s++) begin
                key_l[8*s +: 8]   = k_sh[s][127-8*j -: 8];
                nonce_l[8*s +: 8] = n_sh[s][127-8*j -: 8];
                if (j < 5)  ad_l[8*s +: 8] = a_sh[s][39-8*j -: 8];
                else        ad_l[8*s +: 8] = 8'hA5;
                if (j < 10) ct_l[8*s +: 8] = c_sh[s][79-8*j -: 8];
                else        ct_l[8*s +: 8] = 8'h3C;
            end
            if (gapped && j < 15) begin
                @(negedge clk);
                if (loaded)     early_loaded++;
                if (core_start) start_seen++;
                in_valid = 1'b0;
                dstart   = 1'b1;
                key_l = 24'h5a5a5a; nonce_l = 24'h5a5a5a; ad_l = 24'h5a5a5a; ct_l = 24'h5a5a5a;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        dstart   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({loaded, core_start, out_valid, done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {loaded, core_start, out_valid, done}); end
        checks++; if ({pt_byte, tag_byte} !== 16'h0) begin errors++; $display("FAIL reset_bytes: got %h expected 0000", {pt_byte, tag_byte}); end
        checks++; if (key_sh !== '0 || nonce_sh !== '0 || ad_sh !== '0 || ct_sh !== '0) begin errors++; $display("FAIL reset_shares: got nonzero share registers, expected 0"); end
        rst = 1'b1;
    endtask

    task automatic test_unmasked_load();
        int el, ss;
        apply_reset();
        set_unmasked();
        drive_load(1'b0, el, ss);
        checks++; if (el !== 0) begin errors++; $display("FAIL unmasked_early_loaded: got %0d cycles expected 0", el); end
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL unmasked_loaded: got %b expected 1", loaded); end
        checks++; if (key_sh[127:0] !== KEY) begin errors++; $display("FAIL unmasked_key: got %h expected %h", key_sh[127:0], KEY); end
        checks++; if (nonce_sh[127:0] !== NONCE) begin errors++; $display("FAIL unmasked_nonce: got %h expected %h", nonce_sh[127:0], NONCE); end
        checks++; if (ad_sh[39:0] !== AD) begin errors++; $display("FAIL unmasked_ad: got %h expected %h", ad_sh[39:0], AD); end
        checks++; if (ct_sh[79:0] !== CT) begin errors++; $display("FAIL unmasked_ct: got %h expected %h", ct_sh[79:0], CT); end
        checks++; if (key_sh[383:128] !== '0 || ct_sh[239:80] !== '0) begin errors++; $display("FAIL unmasked_zero_shares: got %h expected 0", ct_sh[239:80]); end
    endtask

    task automatic test_masked_load();
        int el, ss;
        apply_reset();
        set_masked();
        drive_load(1'b0, el, ss);
        checks++; if ((key_sh[127:0] ^ key_sh[255:128] ^ key_sh[383:256]) !== KEY) begin errors++; $display("FAIL masked_key: got %h expected %h", key_sh[127:0] ^ key_sh[255:128] ^ key_sh[383:256], KEY); end
        checks++; if ((nonce_sh[127:0] ^ nonce_sh[255:128] ^ nonce_sh[383:256]) !== NONCE) begin errors++; $display("FAIL masked_nonce: got %h expected %h", nonce_sh[127:0] ^ nonce_sh[255:128] ^ nonce_sh[383:256], NONCE); end
        checks++; if ((ad_sh[39:0] ^ ad_sh[79:40] ^ ad_sh[119:80]) !== AD) begin errors++; $display("FAIL masked_ad: got %h expected %h", ad_sh[39:0] ^ ad_sh[79:40] ^ ad_sh[119:80], AD); end
        checks++; if ((ct_sh[79:0] ^ ct_sh[159:80] ^ ct_sh[239:160]) !== CT) begin errors++; $display("FAIL masked_ct: got %h expected %h", ct_sh[79:0] ^ ct_sh[159:80] ^ ct_sh[239:160], CT); end
        checks++; if (ct_sh[159:80] !== c_sh[1]) begin errors++; $display("FAIL masked_ct_share1: got %h expected %h", ct_sh[159:80], c_sh[1]); end
    endtask

    task automatic test_gapped_load();
        int el, ss;
        apply_reset();
        set_masked();
        drive_load(1'b1, el, ss);
        checks++; if (el !== 0) begin errors++; $display("FAIL gapped_early_loaded: got %0d cycles expected 0", el); end
        checks++; if (ss !== 0) begin errors++; $display("FAIL gapped_early_start: got %0d pulses expected 0", ss); end
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL gapped_loaded: got %b expected 1", loaded); end
        checks++; if ((key_sh[127:0] ^ key_sh[255:128] ^ key_sh[383:256]) !== KEY) begin errors++; $display("FAIL gapped_key: got %h expected %h", key_sh[127:0] ^ key_sh[255:128] ^ key_sh[383:256], KEY); end
        checks++; if ((ct_sh[79:0] ^ ct_sh[159:80] ^ ct_sh[239:160]) !== CT) begin errors++; $display("FAIL gapped_ct: got %h expected %h", ct_sh[79:0] ^ ct_sh[159:80] ^ ct_sh[239:160], CT); end
        // core_ready while still in LOAD must not start an unload
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL ready_in_load: got valid=%b start=%b expected 0 0", out_valid, core_start); end
    endtask

    task automatic test_start_unload();
        logic [7:0] exp_pt, exp_tag;
        dstart = 1'b1;
        @(negedge clk);
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", core_start); end
        @(negedge clk);
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_single_2: got %b expected 0", core_start); end
        @(negedge clk);
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_single_3: got %b expected 0", core_start); end
        dstart = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL run_valid: got %b expected 0", out_valid); end
        core_ready = 1'b1;
        core_pt    = 80'h0102030405060708090a;
        core_tag   = 128'h000102030405060708090a0b0c0d0e0f;
        out_ready  = 1'b1;
        for (int o = 0; o < 16; o++) begin
            @(negedge clk);
            core_ready = 1'b0;
            core_pt = '0; core_tag = '0;
            exp_pt  = (o < 10) ? 8'(10 - o) : 8'h00;
            exp_tag = 8'(15 - o);
            checks++; if (out_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL unload_valid[%0d]: got valid=%b done=%b expected 1 0", o, out_valid, done); end
            checks++; if (pt_byte !== exp_pt) begin errors++; $display("FAIL unload_pt[%0d]: got %h expected %h", o, pt_byte, exp_pt); end
            checks++; if (tag_byte !== exp_tag) begin errors++; $display("FAIL unload_tag[%0d]: got %h expected %h", o, tag_byte, exp_tag); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fin_done: got done=%b valid=%b expected 1 0", done, out_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || loaded !== 1'b0) begin errors++; $display("FAIL fin_once: got done=%b loaded=%b expected 0 0", done, loaded); end
    endtask

    task automatic test_backpressure();
        int el, ss, o, stall, cyc;
        logic [7:0] exp_pt, exp_tag;
        drive_load(1'b0, el, ss);
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reload_loaded: got %b expected 1", loaded); end
        dstart = 1'b1;
        @(negedge clk);
        dstart = 1'b0;
        repeat (2) @(negedge clk);
        core_ready = 1'b1;
        core_pt    = 80'h1112131415161718191a;
        core_tag   = 128'h00102030405060708090a0b0c0d0e0f0;
        out_ready  = 1'b1;
        o = 0; stall = 0; cyc = 0;
        while (o < 16 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            core_ready = 1'b0;
            exp_pt  = (o < 10) ? 8'(8'h1a - o) : 8'h00;
            exp_tag = 8'((15 - o) * 16);
            checks++; if (out_valid !== 1'b1 || pt_byte !== exp_pt || tag_byte !== exp_tag) begin errors++; $display("FAIL bp_byte[%0d]: got valid=%b pt=%h tag=%h expected 1 %h %h", o, out_valid, pt_byte, tag_byte, exp_pt, exp_tag); end
            if (o == 5 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                o++;
            end
        end
        checks++; if (o !== 16 || stall !== 3) begin errors++; $display("FAIL bp_count: got bytes=%0d stalls=%0d expected 16 3", o, stall); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_unload();
        int el, ss;
        drive_load(1'b0, el, ss);
        dstart = 1'b1;
        @(negedge clk);
        dstart = 1'b0;
        core_ready = 1'b1;
        core_pt    = 80'h0102030405060708090a;
        core_tag   = 128'h000102030405060708090a0b0c0d0e0f;
        out_ready  = 1'b1;
        for (int o = 0; o < 4; o++) begin
            @(negedge clk);
            core_ready = 1'b0;
            checks++; if (pt_byte !== 8'(10 - o)) begin errors++; $display("FAIL mid_pt[%0d]: got %h expected %h", o, pt_byte, 8'(10 - o)); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({out_valid, done, core_start, loaded} !== 4'b0000 || {pt_byte, tag_byte} !== 16'h0) begin errors++; $display("FAIL mid_reset_out: got flags=%b bytes=%h expected 0000 0000", {out_valid, done, core_start, loaded}, {pt_byte, tag_byte}); end
        checks++; if (key_sh !== '0 || ct_sh !== '0) begin errors++; $display("FAIL mid_reset_shares: got nonzero, expected 0"); end
        rst = 1'b1;
        out_ready = 1'b0;
        // Start is ignored in LOAD until a full load completes.
        dstart = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dstart = 1'b0;
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL mid_reset_start: got %b expected 0", core_start); end
        set_unmasked();
        drive_load(1'b0, el, ss);
        checks++; if (loaded !== 1'b1 || key_sh[127:0] !== KEY || ad_sh[39:0] !== AD) begin errors++; $display("FAIL post_reset_load: got loaded=%b key=%h expected 1 %h", loaded, key_sh[127:0], KEY); end
    endtask

    initial begin
        test_reset();
        test_unmasked_load();
        test_masked_load();
        test_gapped_load();
        test_start_unload();
        test_backpressure();
        test_reset_mid_unload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_serial_io.md
# ascon_serial_io

Byte-serial host interface for the Ascon decryption core. It accepts key, nonce, associated data and ciphertext as 24-bit lanes, one byte per cycle, each lane carrying three 8-bit shares. It reassembles the shares into parallel registers and issues a one-cycle start to the core. When the core reports completion, it streams plaintext and tag back out a byte per cycle under a valid/ready handshake. It sits between the pad/host bus and the Ascon datapath.

## Interface
Parameters:
- K, 128: key width in bits; multiple of 8.
- L, 40: associated-data width in bits; multiple of 8.
- Y, 80: plaintext/ciphertext width in bits; multiple of 8.
- Derived localparams, not overridable:
  - MAX = max(K, L, Y, 128).
  - NIN = MAX/8.
  - NOUT = max(Y, 128)/8.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- keyxSI, noncexSI, associated_dataxSI, cipher_textxSI  in  24 each  input lanes; bits [7:0] are share 0, [15:8] share 1, [23:16] share 2.
- in_validxSI  in  1  the current lane byte is valid.
- decryption_startxSI  in  1  host command to start decryption.
- loadedxSO  out  1  all NIN bytes have been captured.
- key_shxSO  out  3K  key shares; bits [s*K +: K] hold share s.
- nonce_shxSO  out  384  nonce shares, same layout.
- ad_shxSO  out  3L  associated-data shares, same layout.
- ct_shxSO  out  3Y  ciphertext shares, same layout.
- core_startxSO  out  1  start pulse to the core.
- core_readyxSI  in  1  core has finished.
- core_ptxSI  in  Y  recombined plaintext from the core.
- core_tagxSI  in  128  tag from the core.
- plain_textxSO, tagxSO  out  8 each  output bytes.
- out_validxSO  out  1  output byte pair is valid.
- out_readyxSI  in  1  host accepts the output byte pair.
- donexSO  out  1  one-cycle pulse after the last output byte.

## Operation
- The FSM has four states: LOAD, RUN, UNLOAD, FIN.
- LOAD, per accepted byte:
  - A byte is accepted when in_validxSI=1; index j runs 0..NIN-1.
  - For a field F of width W, when j < W/8: byte bit b of share s is written to F_s[W-1-8j-(7-b)]. This is MSB-first, and lane bit 7 maps to the field's highest remaining bit.
  - When j >= W/8, the byte is ignored for that field. The nonce uses W=128.
- LOAD, completion and start:
  - After byte NIN-1 is accepted, loadedxSO is set and further in_validxSI is ignored.
  - decryption_startxSI is ignored while loadedxSO=0.
  - With loadedxSO=1, decryption_startxSI=1 moves the FSM to RUN.
- RUN:
  - core_startxSO is high for exactly the first RUN cycle.
  - The FSM waits for core_readyxSI=1. On that edge it captures core_ptxSI and core_tagxSI and moves to UNLOAD.
- UNLOAD:
  - For output index o = 0..NOUT-1: plain_textxSO = pt[8o+7:8o] when o < Y/8, else 0.
  - tagxSO = tag[8o+7:8o] when o < 16, else 0.
  - This is LSB byte first, with bit order preserved inside each byte.
  - o advances only on out_validxSO & out_readyxSI. Data stays stable while out_readyxSI=0.
- FIN:
  - Lasts one cycle and pulses donexSO.
  - Clears loadedxSO, the byte counters and the captured PT/tag.
  - Returns to LOAD. The share registers keep their values until they are overwritten.
- Shares are never recombined in this block. The true value of a field is the XOR of its three shares.

## Timing
- Reset (rst=0 at a rising edge):
  - State becomes LOAD.
  - All share, PT and tag registers become 0.
  - Counters become 0.
  - All outputs become 0.
  - Reset has priority over every other input in every state, including mid-load and mid-unload.
- Load:
  - A byte presented in cycle t is visible in the share outputs from cycle t+1.
  - loadedxSO rises in the cycle after the NIN-th accepted byte. The minimum load is NIN cycles.
- Start:
  - decryption_startxSI sampled high at edge t gives core_startxSO high during cycle t+1 only, even if start is held.
- Core completion:
  - core_readyxSI sampled at edge t gives out_validxSO=1 from cycle t+1.
  - core_readyxSI outside RUN is ignored.
- Unload:
  - out_validxSO stays high until the last handshake.
  - The last handshake at edge t is followed by FIN in cycle t+1 (donexSO=1), then LOAD in cycle t+2.
  - With out_readyxSI tied high, unload takes NOUT cycles.
- Simultaneous events:
  - in_validxSI during RUN, UNLOAD or FIN is ignored.
  - decryption_startxSI during RUN or UNLOAD is ignored.

## Structure
- The package ascon_io_pkg holds:
  - the state enum;
  - the share count (3) and lane width (8);
  - a max function used for MAX and NOUT.
- One sub-module, ascon_share_field #(W): three W-bit share registers with byte-indexed MSB-first insertion. It is instantiated once each for key, nonce, AD and CT.
- The FSM, counters and output mux stay in the top module.

## Test plan
- Unmasked load:
  - Stimulus: shares 1/2 = 0, with KEY=2db083053e848cefa30007336c47a5a1, NONCE=3f3607dbce3503ba84f5843d623de056, AD=4153434f4e, CT=87a59a2ea49b233259e3.
  - Response: share0 equals each field; loadedxSO rises after exactly 16 accepted bytes.
- Masked load:
  - Stimulus: random shares 1/2, with share 0 = value ^ s1 ^ s2.
  - Response: the XOR of the three share outputs equals KEY/NONCE/AD/CT.
- Gapped load:
  - Stimulus: in_validxSI toggling 1,0,1,0.
  - Response: only valid bytes are counted; loadedxSO rises after the 16th valid byte; start before that is ignored.
- Start and unload:
  - Stimulus: decryption_startxSI held for 3 cycles; core_readyxSI raised 5 cycles later with pt=0x0102030405060708090a and tag=0x00..0f.
  - Response: core_startxSO is a single pulse; out bytes are 0x0a,0x09,…,0x01, then 0x00 ×6; tag bytes are 0x0f,0x0e,…,0x00; donexSO pulses once.
- Backpressure:
  - Stimulus: out_readyxSI low for 3 cycles mid-stream.
  - Response: bytes are held stable; none is dropped or duplicated.
- Reset mid-unload:
  - Stimulus: rst=0 after 4 output bytes.
  - Response: all outputs are 0 next cycle; state is LOAD; a fresh load then works.
